// File: rtl/regfile_ctl_pkg.sv
// Shared constants for the integer register-file write-back control slice.
package regfile_ctl_pkg;
    localparam int RF_XLEN = 32;   // register data width
    localparam int RF_AW   = 5;    // register index width
    localparam int RF_NREG = 32;   // number of architectural registers (x0..x31)
    localparam int RF_NREQ = 3;    // default write-back requesters: ALU, load unit, CSR unit
endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search begins one past the last granted index.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;

    // Pick the first requester after ptr, wrapping around; ptr itself is checked last.
    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Remember the last winner; reset to N-1 so requester 0 is favoured first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PW'(N - 1);
        end else if (advance) begin
            ptr <= gnt_idx;
        end
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates requesters onto the register file write
// port, registers that port, and tracks per-register busy bits for hazards.
module regfile_wb_ctrl
    import regfile_ctl_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wb_req,
    input  logic [NREQ*AW-1:0]   wb_rd,
    input  logic [NREQ*XLEN-1:0] wb_data,
    output logic [NREQ-1:0]      wb_gnt,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_rd,
    output logic                 rsv_ready,
    input  logic [AW-1:0]        q_rs1,
    input  logic [AW-1:0]        q_rs2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_rw,
    output logic [XLEN-1:0]      rf_busw
);
    localparam int NREG = RF_NREG;

    logic [NREQ-1:0] arb_gnt;
    logic            gnt_any;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_nxt;
    logic [NREG-1:0] busy_vec;
    logic            set_en;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wb_req),
        .advance (gnt_any),
        .gnt     (arb_gnt)
    );

    // Grants are suppressed while reset is held so no handshake can complete.
    always_comb begin
        wb_gnt  = rst ? '0 : arb_gnt;
        gnt_any = |wb_gnt;
    end

    // Steer the granted requester's destination and data toward the write port.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wb_gnt[i]) begin
                sel_rd   = wb_rd[i*AW +: AW];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // Registered write port; x0 writes are consumed but never enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_rw   <= '0;
            rf_busw <= '0;
        end else if (gnt_any && (sel_rd != '0)) begin
            rf_we   <= 1'b1;
            rf_rw   <= sel_rd;
            rf_busw <= sel_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    // Reservation may proceed when the destination is free, retiring right now, or x0.
    always_comb begin
        busy_vec  = {busy_q, 1'b0};
        rsv_ready = !busy_vec[rsv_rd] || (rf_we && (rf_rw == rsv_rd)) || (rsv_rd == '0);
        set_en    = rsv_valid && rsv_ready && (rsv_rd != '0);
        q_busy1   = busy_vec[q_rs1];
        q_busy2   = busy_vec[q_rs2];
    end

    // Next busy state: a new reservation beats the clear from a retiring write.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            busy_nxt[i] = (set_en && (rsv_rd == AW'(i))) ||
                          (busy_q[i] && !(rf_we && (rf_rw == AW'(i))));
        end
    end

    // Busy scoreboard state; x0 is implicitly never busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: reference model plus scoreboard
// queue of expected write-port values, and directed scenario checks.
module tb_regfile_wb_ctrl;
    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   rw;
        logic [XLEN-1:0] data;
    } wr_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   rd_bus;
    logic [NREQ*XLEN-1:0] data_bus;
    logic [NREQ-1:0]      gnt;
    logic                 rsv_valid;
    logic [AW-1:0]        rsv_rd;
    logic                 rsv_ready;
    logic [AW-1:0]        q_rs1;
    logic [AW-1:0]        q_rs2;
    logic                 q_busy1;
    logic                 q_busy2;
    logic                 rf_we;
    logic [AW-1:0]        rf_rw;
    logic [XLEN-1:0]      rf_busw;

    int n_chk = 0;
    int n_err = 0;

    wr_t        exp_q[$];
    int         ptr_m;
    logic [31:0] busy_m;

    logic [NREQ-1:0] obs_gnt;
    logic            obs_we;
    logic [AW-1:0]   obs_rw;
    logic [XLEN-1:0] obs_data;
    logic            obs_ready;
    logic            obs_b1;
    logic            obs_b2;
    logic [NREQ-1:0] order[6];

    regfile_wb_ctrl #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_req    (req),
        .wb_rd     (rd_bus),
        .wb_data   (data_bus),
        .wb_gnt    (gnt),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .rsv_ready (rsv_ready),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .rf_we     (rf_we),
        .rf_rw     (rf_rw),
        .rf_busw   (rf_busw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] model_gnt(input int p, input logic [NREQ-1:0] r);
        logic [NREQ-1:0] g;
        g = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (g == '0 && r[(p + k) % NREQ]) g[(p + k) % NREQ] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back('0);
        ptr_m  = NREQ - 1;
        busy_m = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        req[i] = 1'b1;
        rd_bus[i*AW +: AW] = rd;
        data_bus[i*XLEN +: XLEN] = d;
    endtask

    task automatic clear_inputs();
        req = '0;
        rd_bus = '0;
        data_bus = '0;
        rsv_valid = 1'b0;
        rsv_rd = '0;
        q_rs1 = '0;
        q_rs2 = '0;
    endtask

    // One clock cycle: compare DUT against the model at negedge, advance the model.
    task automatic tick();
        wr_t e;
        wr_t n;
        logic [NREQ-1:0] g;
        logic rdy;
        int gi;
        @(negedge clk);
        obs_gnt = gnt; obs_we = rf_we; obs_rw = rf_rw; obs_data = rf_busw;
        obs_ready = rsv_ready; obs_b1 = q_busy1; obs_b2 = q_busy2;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        g = model_gnt(ptr_m, req);
        check("wb_gnt", 64'(gnt), 64'(g));
        check("rf_we", 64'(rf_we), 64'(e.we));
        check("rf_rw", 64'(rf_rw), 64'(e.rw));
        check("rf_busw", 64'(rf_busw), 64'(e.data));
        rdy = !busy_m[rsv_rd] || (e.we && e.rw == rsv_rd) || (rsv_rd == 0);
        check("rsv_ready", 64'(rsv_ready), 64'(rdy));
        check("q_busy1", 64'(q_busy1), 64'(busy_m[q_rs1]));
        check("q_busy2", 64'(q_busy2), 64'(busy_m[q_rs2]));
        n = e;
        n.we = 1'b0;
        gi = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
        if (gi >= 0 && rd_bus[gi*AW +: AW] != 0) begin
            n.we = 1'b1;
            n.rw = rd_bus[gi*AW +: AW];
            n.data = data_bus[gi*XLEN +: XLEN];
        end
        exp_q.push_back(n);
        if (e.we) busy_m[e.rw] = 1'b0;
        if (rsv_valid && rdy && rsv_rd != 0) busy_m[rsv_rd] = 1'b1;
        if (gi >= 0) ptr_m = gi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        // Reset state, with requests present to confirm grants are held off.
        repeat (2) @(posedge clk);
        req = '1;
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_rw", 64'(rf_rw), 64'd0);
        check("rst_busw", 64'(rf_busw), 64'd0);
        check("rst_busy", 64'(q_busy1), 64'd0);
        @(posedge clk);
        #1;
        do_reset();

        // Single write: reserve x5, then requester 1 writes it.
        rsv_valid = 1'b1; rsv_rd = 5'd5;
        tick();
        rsv_valid = 1'b0; q_rs1 = 5'd5;
        set_req(1, 5'd5, 32'hDEADBEEF);
        tick();
        check("sw_gnt", 64'(obs_gnt), 64'b010);
        check("sw_busy_req", 64'(obs_b1), 64'd1);
        req = '0;
        tick();
        check("sw_we", 64'(obs_we), 64'd1);
        check("sw_rw", 64'(obs_rw), 64'd5);
        check("sw_data", 64'(obs_data), 64'hDEADBEEF);
        check("sw_busy_wr", 64'(obs_b1), 64'd1);
        tick();
        check("sw_busy_after", 64'(obs_b1), 64'd0);
        check("sw_we_after", 64'(obs_we), 64'd0);

        // Round-robin fairness with all three requesters held.
        do_reset();
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        for (int c = 0; c < 6; c++) begin
            tick();
            order[c] = obs_gnt;
            if (c > 0) check("rr_we", 64'(obs_we), 64'd1);
        end
        check("rr_0", 64'(order[0]), 64'b001);
        check("rr_1", 64'(order[1]), 64'b010);
        check("rr_2", 64'(order[2]), 64'b100);
        check("rr_3", 64'(order[3]), 64'b001);
        check("rr_4", 64'(order[4]), 64'b010);
        check("rr_5", 64'(order[5]), 64'b100);

        // WAW stall: x7 busy until its write retires, set beats clear.
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        tick();
        tick();
        check("waw_stall", 64'(obs_ready), 64'd0);
        set_req(0, 5'd7, 32'hCAFE_0007);
        tick();
        check("waw_stall_gnt", 64'(obs_ready), 64'd0);
        req = '0;
        tick();
        check("waw_we", 64'(obs_we), 64'd1);
        check("waw_ready", 64'(obs_ready), 64'd1);
        rsv_valid = 1'b0; q_rs1 = 5'd7;
        tick();
        check("waw_set_wins", 64'(obs_b1), 64'd1);

        // x0 discard: granted and consumed, never written or reserved.
        do_reset();
        set_req(0, 5'd0, 32'h0000_1234);
        rsv_valid = 1'b1; rsv_rd = 5'd0; q_rs1 = 5'd0;
        tick();
        check("x0_gnt", 64'(obs_gnt), 64'b001);
        check("x0_ready", 64'(obs_ready), 64'd1);
        check("x0_busy", 64'(obs_b1), 64'd0);
        req = '0;
        tick();
        check("x0_we", 64'(obs_we), 64'd0);

        // Hazard query on x3 versus x4.
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd3;
        tick();
        rsv_valid = 1'b0; q_rs1 = 5'd3; q_rs2 = 5'd4;
        tick();
        check("hz_b1", 64'(obs_b1), 64'd1);
        check("hz_b2", 64'(obs_b2), 64'd0);
        set_req(2, 5'd3, 32'h0BAD_F00D);
        tick();
        req = '0;
        tick();
        check("hz_b1_wr", 64'(obs_b1), 64'd1);
        tick();
        check("hz_b1_ret", 64'(obs_b1), 64'd0);

        // Async reset mid-cycle while a write is on the port and x4..x7 busy.
        do_reset();
        for (int r = 4; r <= 7; r++) begin
            rsv_valid = 1'b1; rsv_rd = AW'(r);
            tick();
        end
        rsv_valid = 1'b0;
        set_req(2, 5'd9, 32'h5A5A_A5A5);
        tick();
        set_req(0, 5'd10, 32'h1);
        set_req(1, 5'd11, 32'h2);
        q_rs1 = 5'd4;
        #2;
        check("ar_pre_we", 64'(rf_we), 64'd1);
        check("ar_pre_busy", 64'(q_busy1), 64'd1);
        rst = 1'b1;
        #1;
        check("ar_we", 64'(rf_we), 64'd0);
        check("ar_gnt", 64'(gnt), 64'd0);
        for (int r = 4; r <= 7; r++) begin
            q_rs1 = AW'(r);
            #1;
            check("ar_busy", 64'(q_busy1), 64'd0);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        q_rs1 = 5'd0;
        tick();
        check("ar_first_gnt", 64'(obs_gnt), 64'b001);
        req = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
